hough_frame_sequencer: RTL and testbench
========================================

# hough_frame_sequencer

Sequences one Hough_Transform instance over a binary edge frame: reads edge pixels from the frame buffer, feeds ROI-local coordinates to the transform, and handshakes clear/enable/done per pixel. Processes ROI_L then ROI_R on the same transform, resetting its accumulator before each side. Captures m, b and lane_departure per side and publishes them to the lane overlay/line drawer once per frame.

## Interface
- ROI_L_X0 / ROI_L_X1, default 0 / 319: ROI_L column bounds, inclusive.
- ROI_R_X0 / ROI_R_X1, default 320 / 639: ROI_R column bounds, inclusive.
- ROI_Y0 / ROI_Y1, default 240 / 479: row bounds shared by both ROIs, inclusive.
- RESULT_WAIT, default 4: cycles from the last vote until m/b are stable.
- VOTE_TIMEOUT, default 255: maximum VOTE cycles before a pixel is abandoned.
- CLK100MHZ  in  1: single clock.
- reset  in  1: synchronous, active-high.
- start  in  1: 1-cycle pulse; begins a frame. Ignored unless idle.
- busy  out  1: high from the cycle after an accepted start until frame_done.
- frame_done  out  1: 1-cycle pulse when both sides are captured.
- result_valid  out  1: cleared on accepted start, set together with frame_done.
- vote_timeout_err  out  1: sticky per frame, cleared on start.
- pix_rd_en  out  1: frame buffer read strobe.
- pix_x, pix_y  out  12: absolute frame buffer read address.
- pix_data  in  1: edge bit, valid the cycle after pix_rd_en.
- ht_reset  out  1: drives Hough_Transform reset.
- ht_roi  out  1: 0 = ROI_L, 1 = ROI_R.
- ht_x, ht_y  out  12: ROI-local coordinates (pix_x − ROI x0, pix_y − ROI_Y0).
- ht_pixel  out  1: registered edge bit.
- ht_clear, ht_enable  out  1: per-pixel handshake.
- ht_reset_complete, ht_done, ht_lane_departure  in  1.
- ht_m, ht_b  in  16: m is fixed point at bit 8; b is a signed integer.
- left_m, left_b, right_m, right_b  out  16: captured line parameters.
- left_lane_dep, right_lane_dep  out  1: captured lane departure flags.

## Operation
- States: IDLE, HT_RST, RST_GAP, WAIT_RST, FETCH, LOAD, VOTE, SETTLE, CAPTURE, DONE.
- IDLE + start: side ← L, ht_roi ← 0, coordinates ← (X0, ROI_Y0); go to HT_RST.
- HT_RST: ht_reset = 1 for 1 cycle; then RST_GAP.
- RST_GAP: 1 cycle, ht_reset_complete ignored (it is stale); then WAIT_RST.
- WAIT_RST: hold until ht_reset_complete = 1 (about 2^17 cycles); then FETCH.
- FETCH: pix_rd_en = 1 for 1 cycle; then LOAD.
- LOAD: ht_pixel ← pix_data.
  - pix_data = 0: the transform is not invoked; advance coordinates; go to FETCH, or to SETTLE if this was the last pixel.
  - pix_data = 1: ht_clear = 1 with ht_x/ht_y stable; go to VOTE.
- VOTE: ht_enable = 1; ht_x, ht_y and ht_roi are held.
  - ht_done = 1: ht_enable drops the next cycle; advance; go to FETCH or SETTLE.
  - VOTE_TIMEOUT cycles without ht_done: set vote_timeout_err; treat as done.
- Raster order: x inner, y outer. After (X1, y), go to (X0, y+1). The last pixel is (X1, ROI_Y1).
- SETTLE: ht_enable = 0 and ht_roi held for RESULT_WAIT cycles; then CAPTURE.
- CAPTURE: latch ht_m, ht_b, ht_lane_departure into the current side's outputs.
  - Side L: side ← R, ht_roi ← 1, coordinates ← (ROI_R_X0, ROI_Y0); go to HT_RST.
  - Side R: go to DONE.
- DONE: frame_done = 1 and result_valid ← 1; go to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - All strobes 0: busy, frame_done, pix_rd_en, ht_reset, ht_clear, ht_enable, result_valid, vote_timeout_err.
  - ht_roi, ht_pixel 0.
  - pix_x/pix_y and ht_x/ht_y 0.
  - All captured m/b outputs 0; both lane departure flags 0.
- Reset mid-frame: abort immediately to IDLE with the values above. The transform's own reset is the system's job.
- Zero pixel costs 2 cycles. Set pixel costs 2 + k cycles, where k is the VOTE cycle on which ht_done is seen (about 71).
- ht_clear and ht_enable are never high in the same cycle.
- ht_roi changes only in CAPTURE or IDLE, never while the transform is voting or settling.
- Captured outputs hold the previous frame's values until overwritten in CAPTURE. result_valid is the qualifier.
- start in the same cycle as reset: reset wins.
- Degenerate ROI (X0 = X1, Y0 = Y1): exactly one pixel is processed.

## Structure
- Shared header hough_defs.vh: state encodings, COORD_W = 12, PARAM_W = 16, ROI select constants ROI_L = 0, ROI_R = 1.
- Sub-module roi_raster_counter:
  - Loadable x/y counter with inclusive bounds.
  - Outputs: absolute coordinates, ROI-local coordinates, and a `last` flag.
  - Advance input.

## Test plan
- ROI 4×2, all pix_data = 0 → ht_enable never asserted; 16 FETCHs plus reset waits; frame_done; result_valid = 1.
- Single set pixel at ROI_L (X0+3, Y0+1) → one ht_clear with ht_x = 3, ht_y = 1, ht_roi = 0, followed by an ht_enable run ending the cycle after ht_done.
- Transform model drives ht_m = 0x0180, ht_b = 0x0050 for L and 0xFE80, 0x0060 for R → left_m = 0x0180, right_b = 0x0060; captured RESULT_WAIT cycles after the last vote.
- Model never asserts ht_done → ht_enable drops after 255 VOTE cycles; vote_timeout_err = 1; raster continues.
- reset asserted during VOTE on ROI_R → next cycle: IDLE, busy = 0, ht_enable = 0, all captured outputs 0.
- start pulsed while busy → ignored; exactly one frame_done.

Source files
------------

// File: rtl/hough_frame_sequencer_pkg.sv
// Shared definitions for the Hough frame sequencer: widths, ROI select codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package hough_frame_sequencer_pkg;

  localparam int COORD_W = 12;
  localparam int PARAM_W = 16;

  localparam logic ROI_L = 1'b0;
  localparam logic ROI_R = 1'b1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PARAM_W-1:0] param_t;

  typedef enum logic [3:0] {
    IDLE,
    HT_RST,
    RST_GAP,
    WAIT_RST,
    FETCH,
    LOAD,
    VOTE,
    SETTLE,
    CAPTURE,
    DONE
  } seq_state_t;

  // Narrow an elaboration-time integer (ROI bound) to a coordinate.
  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/hough_frame_sequencer_if.sv
// Frame buffer read port plus Hough_Transform control/result signals.
// Latency: pix_data follows pix_rd_en by one cycle; ht_done follows ht_enable by a transform-defined time.
// Backpressure: none on the read port; the transform throttles through ht_reset_complete and ht_done.
// Ports: master = sequencer side, slave = frame buffer + transform side.
interface hough_frame_sequencer_if;
  import hough_frame_sequencer_pkg::*;

  logic   pix_rd_en;
  coord_t pix_x;
  coord_t pix_y;
  logic   pix_data;

  logic   ht_reset;
  logic   ht_roi;
  coord_t ht_x;
  coord_t ht_y;
  logic   ht_pixel;
  logic   ht_clear;
  logic   ht_enable;
  logic   ht_reset_complete;
  logic   ht_done;
  logic   ht_lane_departure;
  param_t ht_m;
  param_t ht_b;

  modport master (
    output pix_rd_en, pix_x, pix_y,
    output ht_reset, ht_roi, ht_x, ht_y, ht_pixel, ht_clear, ht_enable,
    input  pix_data,
    input  ht_reset_complete, ht_done, ht_lane_departure, ht_m, ht_b
  );

  modport slave (
    input  pix_rd_en, pix_x, pix_y,
    input  ht_reset, ht_roi, ht_x, ht_y, ht_pixel, ht_clear, ht_enable,
    output pix_data,
    output ht_reset_complete, ht_done, ht_lane_departure, ht_m, ht_b
  );

endinterface

// File: rtl/hough_frame_sequencer_roi_raster_counter.sv
// ROI raster counter: walks an inclusive box x-inner / y-outer from (x0,y0) to (x1,y1).
// Latency: load/advance take effect on the next clock.
// Backpressure: holds position whenever advance is low.
// Ports: clk, reset (sync, active-high); load + x0/x1/y0/y1 start a walk; advance steps one pixel;
//        abs_x/abs_y frame coordinates, loc_x/loc_y ROI-local coordinates, last marks (x1,y1).
module hough_frame_sequencer_roi_raster_counter
  import hough_frame_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  coord_t x0,
  input  coord_t x1,
  input  coord_t y0,
  input  coord_t y1,
  input  logic   advance,
  output coord_t abs_x,
  output coord_t abs_y,
  output coord_t loc_x,
  output coord_t loc_y,
  output logic   last
);

  coord_t x0_q, x1_q, y0_q, y1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q  <= '0;
      x1_q  <= '0;
      y0_q  <= '0;
      y1_q  <= '0;
      abs_x <= '0;
      abs_y <= '0;
    end else if (load) begin
      x0_q  <= x0;
      x1_q  <= x1;
      y0_q  <= y0;
      y1_q  <= y1;
      abs_x <= x0;
      abs_y <= y0;
    end else if (advance) begin
      if (abs_x == x1_q) begin
        abs_x <= x0_q;
        abs_y <= abs_y + coord_t'(1);
      end else begin
        abs_x <= abs_x + coord_t'(1);
      end
    end
  end

  assign loc_x = abs_x - x0_q;
  assign loc_y = abs_y - y0_q;
  assign last  = (abs_x == x1_q) && (abs_y == y1_q);

endmodule

// File: rtl/hough_frame_sequencer.sv
// Drives one Hough_Transform over ROI_L then ROI_R of a binary edge frame; publishes m/b/lane flags per frame.
// Latency: zero pixel 2 cycles, set pixel 2+k cycles; per side adds transform reset wait and RESULT_WAIT settle.
// Backpressure: stalls in WAIT_RST until ht_reset_complete and in VOTE until ht_done or VOTE_TIMEOUT.
// Ports: CLK100MHZ, reset (sync, active-high), start pulse; busy/frame_done/result_valid/vote_timeout_err status;
//        hbus = frame buffer read + transform handshake; left_*/right_* captured line parameters.
module hough_frame_sequencer
  import hough_frame_sequencer_pkg::*;
#(
  parameter int ROI_L_X0     = 0,
  parameter int ROI_L_X1     = 319,
  parameter int ROI_R_X0     = 320,
  parameter int ROI_R_X1     = 639,
  parameter int ROI_Y0       = 240,
  parameter int ROI_Y1       = 479,
  parameter int RESULT_WAIT  = 4,
  parameter int VOTE_TIMEOUT = 255
) (
  input  logic   CLK100MHZ,
  input  logic   reset,
  input  logic   start,
  output logic   busy,
  output logic   frame_done,
  output logic   result_valid,
  output logic   vote_timeout_err,
  hough_frame_sequencer_if.master hbus,
  output param_t left_m,
  output param_t left_b,
  output param_t right_m,
  output param_t right_b,
  output logic   left_lane_dep,
  output logic   right_lane_dep
);

  localparam logic [15:0] VOTE_LAST   = 16'(VOTE_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(RESULT_WAIT - 1);

  seq_state_t  state;
  logic [15:0] wait_cnt;     // VOTE cycle index, reused as SETTLE cycle index
  logic        roi_q;        // also the side currently being processed
  logic        pixel_q;
  logic        rd_en_q;
  logic        ht_reset_q;
  logic        ht_enable_q;

  logic   cnt_load, cnt_adv, cnt_last, pixel_done, vote_expired;
  coord_t load_x0, load_x1;
  coord_t abs_x, abs_y, loc_x, loc_y;

  assign vote_expired = (wait_cnt == VOTE_LAST);

  // A pixel finishes either as a zero in LOAD or when its vote ends (done or timeout).
  assign pixel_done = ((state == LOAD) && !hbus.pix_data) ||
                      ((state == VOTE) && (hbus.ht_done || vote_expired));
  assign cnt_adv    = pixel_done && !cnt_last;

  // Counter is loaded with the left box on start, and the right box while capturing the left side.
  assign cnt_load = ((state == IDLE) && start) || ((state == CAPTURE) && (roi_q == ROI_L));
  assign load_x0  = (state == CAPTURE) ? to_coord(ROI_R_X0) : to_coord(ROI_L_X0);
  assign load_x1  = (state == CAPTURE) ? to_coord(ROI_R_X1) : to_coord(ROI_L_X1);

  hough_frame_sequencer_roi_raster_counter u_raster (
    .clk     (CLK100MHZ),
    .reset   (reset),
    .load    (cnt_load),
    .x0      (load_x0),
    .x1      (load_x1),
    .y0      (to_coord(ROI_Y0)),
    .y1      (to_coord(ROI_Y1)),
    .advance (cnt_adv),
    .abs_x   (abs_x),
    .abs_y   (abs_y),
    .loc_x   (loc_x),
    .loc_y   (loc_y),
    .last    (cnt_last)
  );

  assign hbus.pix_rd_en = rd_en_q;
  assign hbus.pix_x     = abs_x;
  assign hbus.pix_y     = abs_y;
  assign hbus.ht_reset  = ht_reset_q;
  assign hbus.ht_roi    = roi_q;
  assign hbus.ht_x      = loc_x;
  assign hbus.ht_y      = loc_y;
  assign hbus.ht_pixel  = pixel_q;
  assign hbus.ht_enable = ht_enable_q;
  // The edge bit only exists during LOAD, so clear is decoded from it directly
  // to keep a set pixel at 2+k cycles; enable is registered and low in LOAD.
  assign hbus.ht_clear  = (state == LOAD) && hbus.pix_data;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      roi_q            <= ROI_L;
      pixel_q          <= 1'b0;
      rd_en_q          <= 1'b0;
      ht_reset_q       <= 1'b0;
      ht_enable_q      <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      result_valid     <= 1'b0;
      vote_timeout_err <= 1'b0;
      left_m           <= '0;
      left_b           <= '0;
      right_m          <= '0;
      right_b          <= '0;
      left_lane_dep    <= 1'b0;
      right_lane_dep   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy             <= 1'b1;
            result_valid     <= 1'b0;
            vote_timeout_err <= 1'b0;
            roi_q            <= ROI_L;
            ht_reset_q       <= 1'b1;
            state            <= HT_RST;
          end
        end
        HT_RST: begin
          ht_reset_q <= 1'b0;
          state      <= RST_GAP;
        end
        // ht_reset_complete may still show the previous run here.
        RST_GAP: state <= WAIT_RST;
        WAIT_RST: begin
          if (hbus.ht_reset_complete) begin
            rd_en_q <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          rd_en_q <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          pixel_q <= hbus.pix_data;
          if (hbus.pix_data) begin
            ht_enable_q <= 1'b1;
            wait_cnt    <= '0;
            state       <= VOTE;
          end else if (cnt_last) begin
            wait_cnt <= '0;
            state    <= SETTLE;
          end else begin
            rd_en_q <= 1'b1;
            state   <= FETCH;
          end
        end
        VOTE: begin
          if (hbus.ht_done || vote_expired) begin
            ht_enable_q <= 1'b0;
            if (!hbus.ht_done) vote_timeout_err <= 1'b1;
            if (cnt_last) begin
              wait_cnt <= '0;
              state    <= SETTLE;
            end else begin
              rd_en_q <= 1'b1;
              state   <= FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        SETTLE: begin
          if (wait_cnt == SETTLE_LAST) state <= CAPTURE;
          else wait_cnt <= wait_cnt + 16'd1;
        end
        CAPTURE: begin
          if (roi_q == ROI_L) begin
            left_m        <= hbus.ht_m;
            left_b        <= hbus.ht_b;
            left_lane_dep <= hbus.ht_lane_departure;
            roi_q         <= ROI_R;
            ht_reset_q    <= 1'b1;
            state         <= HT_RST;
          end else begin
            right_m        <= hbus.ht_m;
            right_b        <= hbus.ht_b;
            right_lane_dep <= hbus.ht_lane_departure;
            frame_done     <= 1'b1;
            result_valid   <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_frame_sequencer.sv
module tb_hough_frame_sequencer;
  import hough_frame_sequencer_pkg::*;

  logic   CLK100MHZ = 1'b0;
  logic   reset;
  logic   start;
  logic   busy, frame_done, result_valid, vote_timeout_err;
  param_t left_m, left_b, right_m, right_b;
  logic   left_lane_dep, right_lane_dep;

  hough_frame_sequencer_if hbus();

  always #5 CLK100MHZ = ~CLK100MHZ;

  hough_frame_sequencer #(
    .ROI_L_X0(0), .ROI_L_X1(3), .ROI_R_X0(8), .ROI_R_X1(11),
    .ROI_Y0(2), .ROI_Y1(3), .RESULT_WAIT(4), .VOTE_TIMEOUT(255)
  ) dut (
    .CLK100MHZ        (CLK100MHZ),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .frame_done       (frame_done),
    .result_valid     (result_valid),
    .vote_timeout_err (vote_timeout_err),
    .hbus             (hbus),
    .left_m           (left_m),
    .left_b           (left_b),
    .right_m          (right_m),
    .right_b          (right_b),
    .left_lane_dep    (left_lane_dep),
    .right_lane_dep   (right_lane_dep)
  );

  // ---------------- environment models ----------------
  logic   img [0:15][0:15];
  logic   done_mode;
  int     done_k;
  int     vcnt;
  int     rst_cnt;
  param_t m_l, b_l, m_r, b_r;
  logic   dep_l, dep_r;

  always @(posedge CLK100MHZ) begin
    if (reset) hbus.pix_data <= 1'b0;
    else hbus.pix_data <= hbus.pix_rd_en ? img[hbus.pix_y[3:0]][hbus.pix_x[3:0]] : 1'b0;
  end

  always @(posedge CLK100MHZ) begin
    if (hbus.ht_reset) rst_cnt <= 6;
    else if (rst_cnt > 0) rst_cnt <= rst_cnt - 1;
  end
  assign hbus.ht_reset_complete = (rst_cnt == 0) && !hbus.ht_reset;

  always @(posedge CLK100MHZ) vcnt <= hbus.ht_enable ? vcnt + 1 : 0;
  assign hbus.ht_done           = done_mode && hbus.ht_enable && (vcnt == done_k - 1);
  assign hbus.ht_m              = hbus.ht_roi ? m_r : m_l;
  assign hbus.ht_b              = hbus.ht_roi ? b_r : b_l;
  assign hbus.ht_lane_departure = hbus.ht_roi ? dep_r : dep_l;

  // ---------------- scoreboard ----------------
  typedef struct { logic [11:0] x; logic [11:0] y; logic roi; } clr_exp_t;
  typedef struct {
    logic [15:0] lm; logic [15:0] lb; logic [15:0] rm; logic [15:0] rb;
    logic ld; logic rd; logic err; int fetches; int tail;
  } frame_exp_t;

  clr_exp_t   exp_clr_q[$];
  int         exp_run_q[$];
  frame_exp_t exp_frame_q[$];

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int fetch_cnt = 0;
  int since_fetch = 0;
  int run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with no expectation queued", name);
  endtask

  // clear monitor
  always @(negedge CLK100MHZ) begin
    if (!reset && hbus.ht_clear) begin
      if (exp_clr_q.size() == 0) unexpected("clear_unexpected");
      else begin
        clr_exp_t ce;
        ce = exp_clr_q.pop_front();
        check("clear_ht_x", hbus.ht_x, ce.x);
        check("clear_ht_y", hbus.ht_y, ce.y);
        check("clear_ht_roi", hbus.ht_roi, ce.roi);
      end
      check("clear_enable_overlap", hbus.ht_enable, 0);
    end
  end

  // enable run monitor
  always @(negedge CLK100MHZ) begin
    if (reset) run_len = 0;
    else if (hbus.ht_enable) begin
      if (run_len == 0) check("vote_ht_pixel", hbus.ht_pixel, 1);
      run_len++;
    end else if (run_len > 0) begin
      if (exp_run_q.size() == 0) unexpected("enable_run_unexpected");
      else check("enable_run_len", run_len, exp_run_q.pop_front());
      run_len = 0;
    end
  end

  // frame monitor
  always @(negedge CLK100MHZ) begin
    if (reset) begin
      fetch_cnt = 0;
      since_fetch = 0;
    end else begin
      if (hbus.pix_rd_en) begin fetch_cnt++; since_fetch = 0; end
      else since_fetch++;
      if (frame_done) begin
        frames_seen++;
        if (exp_frame_q.size() == 0) unexpected("frame_done_unexpected");
        else begin
          frame_exp_t fe;
          fe = exp_frame_q.pop_front();
          check("left_m", left_m, fe.lm);
          check("left_b", left_b, fe.lb);
          check("right_m", right_m, fe.rm);
          check("right_b", right_b, fe.rb);
          check("lane_deps", {left_lane_dep, right_lane_dep}, {fe.ld, fe.rd});
          check("vote_timeout_err", vote_timeout_err, fe.err);
          check("result_valid_at_done", result_valid, 1);
          check("busy_at_done", busy, 1);
          check("fetch_count", fetch_cnt, fe.fetches);
          check("cycles_last_fetch_to_done", since_fetch, fe.tail);
        end
        fetch_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_img();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = 1'b0;
  endtask

  task automatic set_model(input param_t ml, input param_t bl, input param_t mr, input param_t br,
                           input logic dl, input logic dr);
    m_l = ml; b_l = bl; m_r = mr; b_r = br; dep_l = dl; dep_r = dr;
  endtask

  task automatic wait_enable(input logic want_roi, input string name);
    int n;
    n = 0;
    while (!(hbus.ht_enable && hbus.ht_roi == want_roi) && n < 3000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s: no ht_enable within 3000 cycles", name);
    end
  endtask

  task automatic run_frame(input bit pulse_in_vote);
    int n;
    @(negedge CLK100MHZ); start = 1'b1;
    @(negedge CLK100MHZ); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("result_valid_cleared", result_valid, 0);
    if (pulse_in_vote) begin
      wait_enable(ROI_L, "wait_vote_for_start");
      start = 1'b1;
      @(negedge CLK100MHZ); start = 1'b0;
    end
    n = 0;
    while (busy && n < 4000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL frame_timeout: busy still 1 after 4000 cycles");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done_mode = 1'b1; done_k = 5;
    clear_img();
    set_model(16'h0222, 16'h0011, 16'h0123, 16'h0456, 1'b1, 1'b1);
    repeat (3) @(negedge CLK100MHZ);

    // reset state, with start asserted alongside reset
    start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    check("reset_status", {busy, frame_done, result_valid, vote_timeout_err}, 0);
    check("reset_strobes", {hbus.pix_rd_en, hbus.ht_reset, hbus.ht_clear, hbus.ht_enable,
                            hbus.ht_roi, hbus.ht_pixel}, 0);
    check("reset_coords", {hbus.pix_x, hbus.pix_y, hbus.ht_x, hbus.ht_y}, 0);
    check("reset_captures", {left_m, left_b, right_m, right_b, left_lane_dep, right_lane_dep}, 0);
    reset = 1'b0;
    @(negedge CLK100MHZ);
    check("idle_busy", busy, 0);

    // 1: all-zero frame, no votes
    exp_frame_q.push_back('{16'h0222, 16'h0011, 16'h0123, 16'h0456, 1'b1, 1'b1, 1'b0, 16, 7});
    run_frame(1'b0);

    // 2: last pixel of each ROI set, transform answers on vote 5
    clear_img();
    img[3][3] = 1'b1;
    img[3][11] = 1'b1;
    set_model(16'h0180, 16'h0050, 16'hFE80, 16'h0060, 1'b1, 1'b0);
    exp_clr_q.push_back('{12'd3, 12'd1, 1'b0});
    exp_clr_q.push_back('{12'd3, 12'd1, 1'b1});
    exp_run_q.push_back(5);
    exp_run_q.push_back(5);
    exp_frame_q.push_back('{16'h0180, 16'h0050, 16'hFE80, 16'h0060, 1'b1, 1'b0, 1'b0, 16, 12});
    run_frame(1'b0);

    // 3: transform never answers -> timeout; start pulsed mid-frame is ignored
    clear_img();
    img[2][1] = 1'b1;
    done_mode = 1'b0;
    set_model(16'h0333, 16'h0044, 16'h0555, 16'hFF00, 1'b1, 1'b1);
    exp_clr_q.push_back('{12'd1, 12'd0, 1'b0});
    exp_run_q.push_back(255);
    exp_frame_q.push_back('{16'h0333, 16'h0044, 16'h0555, 16'hFF00, 1'b1, 1'b1, 1'b1, 16, 7});
    run_frame(1'b1);
    repeat (20) @(negedge CLK100MHZ);
    check("start_ignored_stays_idle", busy, 0);

    // 4: reset while voting on ROI_R
    clear_img();
    img[2][9] = 1'b1;
    exp_clr_q.push_back('{12'd1, 12'd0, 1'b1});
    @(negedge CLK100MHZ); start = 1'b1;
    @(negedge CLK100MHZ); start = 1'b0;
    wait_enable(ROI_R, "wait_vote_roi_r");
    repeat (3) @(negedge CLK100MHZ);
    reset = 1'b1;
    @(negedge CLK100MHZ);
    check("midreset_busy", busy, 0);
    check("midreset_ht_enable", hbus.ht_enable, 0);
    check("midreset_flags", {result_valid, vote_timeout_err, frame_done, hbus.ht_roi}, 0);
    check("midreset_captures", {left_m, left_b, right_m, right_b, left_lane_dep, right_lane_dep}, 0);
    reset = 1'b0;
    repeat (10) @(negedge CLK100MHZ);

    check("frames_seen", frames_seen, 3);
    check("clear_queue_drained", exp_clr_q.size(), 0);
    check("run_queue_drained", exp_run_q.size(), 0);
    check("frame_queue_drained", exp_frame_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
